// File: rtl/counter_cmd_gen_pkg.sv
// Shared definitions for the up/down button command generator and the
// counter that consumes its control code.
package counter_cmd_gen_pkg;

  // Command presented to the counter. 2'b11 is reserved and never driven.
  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_INC  = 2'b01,
    CTRL_DEC  = 2'b10
  } ctrl_e;

  // Command generator FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STEP   = 2'b01,
    ST_DELAY  = 2'b10,
    ST_REPEAT = 2'b11
  } state_e;

  // Width of the interval counter: enough for the longer of the two
  // intervals plus one spare bit so it can saturate instead of wrapping.
  function automatic int interval_cnt_width(input int delay_cyc, input int rate_cyc);
    int longest;
    longest = (delay_cyc > rate_cyc) ? delay_cyc : rate_cyc;
    return $clog2(longest) + 1;
  endfunction

  // Control code for a pulse in the latched direction.
  function automatic ctrl_e dir_ctrl(input logic dir_up);
    return dir_up ? CTRL_INC : CTRL_DEC;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter. The debounced
// level only moves once the synchronized input has disagreed with it for
// DEBOUNCE_CYC consecutive cycles; any agreement in between restarts the
// count, so bounces shorter than the window never reach the output.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // Synchronize the raw button and count consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r >= CNT_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= CNT_ZERO;
        end else begin
          cnt_r   <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= CNT_ZERO;
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/counter_cmd_gen.sv
// Turns two raw push buttons into a counter command stream: one step pulse
// on a fresh press, then auto-repeat pulses while the same button is held.
// All outputs are registered and loaded from the next-state decode, so a
// pulse appears in the same cycle the FSM enters STEP or emits a repeat.
module counter_cmd_gen
  import counter_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] control,
  output logic       repeating
);

  localparam int CNT_W = interval_cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  // Debounced button levels.
  logic up_lvl_s;
  logic dn_lvl_s;

  // FSM and datapath registers with their next-state values.
  state_e           state_r;
  state_e           state_s;
  logic             dir_up_r;
  logic             dir_up_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  ctrl_e            ctrl_r;
  ctrl_e            ctrl_s;
  logic             rep_r;
  logic             rep_s;
  // A button that already produced a STEP stays locked until it is seen
  // released, so one long press can never start a second sequence.
  logic             up_lock_r;
  logic             up_lock_s;
  logic             dn_lock_r;
  logic             dn_lock_s;

  // Helpers derived from the latched direction.
  logic             held_s;
  logic             other_s;
  logic [CNT_W-1:0] cnt_inc_s;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .level(up_lvl_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb_dn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .level(dn_lvl_s)
  );

  assign held_s    = dir_up_r ? up_lvl_s : dn_lvl_s;
  assign other_s   = dir_up_r ? dn_lvl_s : up_lvl_s;
  // Saturating increment: the counter holds at all-ones rather than wrap.
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

  // Next-state, interval counter and output decode.
  always_comb begin
    state_s   = state_r;
    dir_up_s  = dir_up_r;
    cnt_s     = cnt_r;
    ctrl_s    = CTRL_HOLD;
    up_lock_s = up_lock_r & up_lvl_s;
    dn_lock_s = dn_lock_r & dn_lvl_s;

    case (state_r)
      ST_IDLE: begin
        if (up_lvl_s && !dn_lvl_s && !up_lock_r) begin
          state_s   = ST_STEP;
          dir_up_s  = 1'b1;
          ctrl_s    = CTRL_INC;
          cnt_s     = CNT_ZERO;
          up_lock_s = 1'b1;
        end else if (dn_lvl_s && !up_lvl_s && !dn_lock_r) begin
          state_s   = ST_STEP;
          dir_up_s  = 1'b0;
          ctrl_s    = CTRL_DEC;
          cnt_s     = CNT_ZERO;
          dn_lock_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      end

      // The step pulse is being shown this cycle; the counter holds the
      // offset since that pulse, so DELAY starts counting from 1.
      ST_STEP: begin
        state_s = ST_DELAY;
        cnt_s   = cnt_inc_s;
      end

      ST_DELAY: begin
        if (!held_s || other_s) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= DELAY_LAST) begin
          state_s = ST_REPEAT;
          ctrl_s  = dir_ctrl(dir_up_r);
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_DELAY;
          cnt_s   = cnt_inc_s;
        end
      end

      ST_REPEAT: begin
        if (!held_s || other_s) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= RATE_LAST) begin
          state_s = ST_REPEAT;
          ctrl_s  = dir_ctrl(dir_up_r);
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_REPEAT;
          cnt_s   = cnt_inc_s;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    rep_s = (state_s == ST_REPEAT);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      dir_up_r  <= 1'b0;
      cnt_r     <= CNT_ZERO;
      ctrl_r    <= CTRL_HOLD;
      rep_r     <= 1'b0;
      up_lock_r <= 1'b0;
      dn_lock_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      dir_up_r  <= dir_up_s;
      cnt_r     <= cnt_s;
      ctrl_r    <= ctrl_s;
      rep_r     <= rep_s;
      up_lock_r <= up_lock_s;
      dn_lock_r <= dn_lock_s;
    end
  end

  assign control   = ctrl_r;
  assign repeating = rep_r;

endmodule

// File: tb/tb_counter_cmd_gen.sv
// Directed bench for counter_cmd_gen with default parameters
// (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5).
// Cycle c is the value seen 1 time unit after the c-th rising edge
// following the last reset edge (edge 0). Inputs change right after an
// edge, so a raw rise driven after edge 0 gives its first pulse at cycle 7.
module tb_counter_cmd_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [1:0] control;
  logic       repeating;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string scen = "init";

  counter_cmd_gen #(
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .control  (control),
    .repeating(repeating)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Two reset edges with buttons low; the last one becomes edge 0.
  task automatic do_reset();
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic check_cycle(input logic [1:0] exp_ctrl, input logic exp_rep);
    check_val($sformatf("%s ctrl c=%0d", scen, cyc), {30'd0, control}, {30'd0, exp_ctrl});
    check_val($sformatf("%s rep c=%0d", scen, cyc), {31'd0, repeating}, {31'd0, exp_rep});
  endtask

  initial begin
    logic [1:0] ec;
    logic       er;

    // Reset state.
    scen = "reset";
    do_reset();
    check_val("reset ctrl", {30'd0, control}, 32'd0);
    check_val("reset rep", {31'd0, repeating}, 32'd0);

    // Single up press held 3 cycles past the pulse: one INC at cycle 7.
    scen = "single_up";
    btn_up = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      ec = (c == 7) ? 2'b01 : 2'b00;
      check_cycle(ec, 1'b0);
      if (c == 10) btn_up = 1'b0;
    end

    // Down held from edge 0 to edge 45: pulses at 7 then offsets 20,25..40
    // (cycles 27,32,37,42,47). Release reaches the FSM at cycle 51, so
    // repeating is high for cycles 27..51 and no pulse appears at 52.
    scen = "hold_down";
    do_reset();
    btn_down = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      ec = (c == 7 || c == 27 || c == 32 || c == 37 || c == 42 || c == 47) ? 2'b10 : 2'b00;
      er = (c >= 27 && c <= 51);
      check_cycle(ec, er);
      if (c == 45) btn_down = 1'b0;
    end

    // Bouncing up: two high, two low, for 20 cycles, then low. Never stable
    // long enough to debounce.
    scen = "bounce";
    do_reset();
    btn_up = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_cycle(2'b00, 1'b0);
      btn_up = (c < 20) ? (((c / 2) % 2) == 0) : 1'b0;
    end

    // Up held; raw down driven after edge 23 so its debounced level is high
    // at cycle 29 (offset 22). FSM drops to IDLE at cycle 30; the repeat at
    // cycle 32 is suppressed. With both held nothing happens. Up released
    // after edge 70 debounces low at cycle 76, leaving only the fresh down
    // press, which steps DEC at cycle 77.
    scen = "cross";
    do_reset();
    btn_up = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      ec = (c == 7 || c == 27) ? 2'b01 : ((c == 77) ? 2'b10 : 2'b00);
      er = (c >= 27 && c <= 29);
      check_cycle(ec, er);
      if (c == 23) btn_down = 1'b1;
      if (c == 70) btn_up = 1'b0;
    end

    // Reset sampled at edge 32, where the offset-25 repeat would fire.
    // Edge 32 becomes the new edge 0 with up still held: next INC at 39.
    scen = "mid_reset";
    do_reset();
    btn_up = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      ec = (c == 7 || c == 27 || c == 39) ? 2'b01 : 2'b00;
      er = (c >= 27 && c <= 31);
      check_cycle(ec, er);
      if (c == 31) reset = 1'b0;
      if (c == 32) reset = 1'b1;
    end

    // Both buttons rise together: nothing ever fires.
    scen = "both";
    do_reset();
    btn_up   = 1'b1;
    btn_down = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_cycle(2'b00, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
